// File: rtl/sev_seg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns,
// decoder FSM states and the pattern-to-hex lookup shared with the display driver.
package sev_seg_pkg;

    typedef logic [6:0] seg_pat_t;

    localparam seg_pat_t SEG_0     = 7'b100_0000;
    localparam seg_pat_t SEG_1     = 7'b111_1001;
    localparam seg_pat_t SEG_2     = 7'b010_0100;
    localparam seg_pat_t SEG_3     = 7'b011_0000;
    localparam seg_pat_t SEG_4     = 7'b001_1001;
    localparam seg_pat_t SEG_5     = 7'b001_0010;
    localparam seg_pat_t SEG_6     = 7'b000_0010;
    localparam seg_pat_t SEG_7     = 7'b111_1000;
    localparam seg_pat_t SEG_8     = 7'b000_0000;
    localparam seg_pat_t SEG_9     = 7'b001_0000;
    localparam seg_pat_t SEG_A     = 7'b000_1000;
    localparam seg_pat_t SEG_B     = 7'b000_0011;
    localparam seg_pat_t SEG_C     = 7'b100_0110;
    localparam seg_pat_t SEG_D     = 7'b010_0001;
    localparam seg_pat_t SEG_E     = 7'b000_0110;
    localparam seg_pat_t SEG_F     = 7'b000_1110;
    localparam seg_pat_t SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_hex(input seg_pat_t pat);
        seg_dec_t dec;
        dec.legal = 1'b1;
        case (pat)
            SEG_0:   dec.nibble = 4'h0;
            SEG_1:   dec.nibble = 4'h1;
            SEG_2:   dec.nibble = 4'h2;
            SEG_3:   dec.nibble = 4'h3;
            SEG_4:   dec.nibble = 4'h4;
            SEG_5:   dec.nibble = 4'h5;
            SEG_6:   dec.nibble = 4'h6;
            SEG_7:   dec.nibble = 4'h7;
            SEG_8:   dec.nibble = 4'h8;
            SEG_9:   dec.nibble = 4'h9;
            SEG_A:   dec.nibble = 4'hA;
            SEG_B:   dec.nibble = 4'hB;
            SEG_C:   dec.nibble = 4'hC;
            SEG_D:   dec.nibble = 4'hD;
            SEG_E:   dec.nibble = 4'hE;
            SEG_F:   dec.nibble = 4'hF;
            default: begin
                dec.legal  = 1'b0;
                dec.nibble = 4'h0;
            end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/sev_seg_sync.sv
// Multi-flop input synchroniser for the asynchronous cat/an lines.
module sev_seg_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];

    // NOTE: the chain is only a few flops, so it is reset explicitly to give a known 0 after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's pre-edge value.
            r_chain[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/sev_seg_decoder.sv
// Receive side of the two-digit multiplexed seven-segment bus: recovers both digits.
// Optional illegal-pattern reporting (err/err_cnt) is enabled by defining SEV_SEG_DEC_ERR_EN.
module sev_seg_decoder
    import sev_seg_pkg::*;
#(
    parameter int GLOBAL_CLOCK_RATE = 100_000_000,
    parameter int REFRESH_RATE      = 200,
    parameter int SETTLE_CYCLES     = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int STALE_MULT        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cat_i,
    input  logic       an_i,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic       dig0_vld,
    output logic       dig1_vld,
    output logic       upd,
    output logic       stale
`ifdef SEV_SEG_DEC_ERR_EN
    ,
    output logic       err,
    output logic [7:0] err_cnt
`endif
);

    localparam int DIV_BY    = GLOBAL_CLOCK_RATE / REFRESH_RATE;
    localparam int STALE_MAX = STALE_MULT * DIV_BY;
    localparam int SW        = $clog2(STALE_MAX + 1);
    localparam int CW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] STALE_TOP   = SW'(STALE_MAX);
    localparam logic [SW-1:0] STALE_LAST  = SW'(STALE_MAX - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [7:0]    w_sync;
    seg_pat_t      w_cat_s;
    logic          w_an_s;
    logic          w_edge;
    logic          w_stable;
    logic          w_settle_done;
    logic          w_stale_hit;
    logic          w_capture;
    logic          w_cnt_run;
    logic          w_wr0;
    logic          w_wr1;
    seg_dec_t      w_dec;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_an_prev;
    seg_pat_t      r_cat_prev;
    logic [CW-1:0] r_set_cnt;
    logic [SW-1:0] r_stale_cnt;
    logic          r_stale;
    logic [3:0]    r_dig0;
    logic [3:0]    r_dig1;
    logic          r_vld0;
    logic          r_vld1;
    logic          r_upd;

    sev_seg_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (8)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({an_i, cat_i}),
        .o_q   (w_sync)
    );

    assign w_an_s        = w_sync[7];
    assign w_cat_s       = w_sync[6:0];
    assign w_edge        = w_an_s ^ r_an_prev;
    assign w_stable      = (w_cat_s == r_cat_prev);
    assign w_settle_done = w_stable && (r_set_cnt == SETTLE_LAST);
    assign w_stale_hit   = !w_edge && (r_stale_cnt == STALE_LAST);
    assign w_dec         = seg_to_hex(w_cat_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SYNC;
        else        r_state <= w_state_nxt;
    end

    // An an_s edge always beats a settle terminal in the same cycle.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        if (w_stale_hit) begin
            w_state_nxt = S_SYNC;
        end else begin
            case (r_state)
                S_SYNC:   if (w_edge) w_state_nxt = S_SETTLE;
                S_SETTLE: if (!w_edge && w_settle_done) w_state_nxt = S_HOLD;
                S_HOLD:   if (w_edge) w_state_nxt = S_SETTLE;
                default:  w_state_nxt = S_SYNC;
            endcase
        end
    end

    always_comb begin
        w_capture = 1'b0;
        w_cnt_run = 1'b0;
        if (r_state == S_SETTLE && !w_edge) begin
            w_capture = w_settle_done && !w_stale_hit;
            w_cnt_run = w_stable && !w_settle_done;
        end
    end

    assign w_wr0 = w_capture && w_dec.legal &&  w_an_s;
    assign w_wr1 = w_capture && w_dec.legal && !w_an_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_prev   <= 1'b0;
            r_cat_prev  <= '0;
            r_set_cnt   <= '0;
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
            r_dig0      <= 4'h0;
            r_dig1      <= 4'h0;
            r_vld0      <= 1'b0;
            r_vld1      <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_an_prev  <= w_an_s;
            r_cat_prev <= w_cat_s;
            r_set_cnt  <= w_cnt_run ? r_set_cnt + 1'b1 : '0;
            r_upd      <= w_wr0 | w_wr1;

            if (w_edge)                        r_stale_cnt <= '0;
            else if (r_stale_cnt != STALE_TOP) r_stale_cnt <= r_stale_cnt + 1'b1;

            if (w_edge)           r_stale <= 1'b0;
            else if (w_stale_hit) r_stale <= 1'b1;

            if (w_wr0) r_dig0 <= w_dec.nibble;
            if (w_wr1) r_dig1 <= w_dec.nibble;

            // Stale invalidates both digits but keeps their last values visible.
            if (w_stale_hit) begin
                r_vld0 <= 1'b0;
                r_vld1 <= 1'b0;
            end else begin
                if (w_wr0) r_vld0 <= 1'b1;
                if (w_wr1) r_vld1 <= 1'b1;
            end
        end
    end

    assign dig0     = r_dig0;
    assign dig1     = r_dig1;
    assign dig0_vld = r_vld0;
    assign dig1_vld = r_vld1;
    assign upd      = r_upd;
    assign stale    = r_stale;

`ifdef SEV_SEG_DEC_ERR_EN
    logic       w_bad;
    logic       r_err;
    logic [7:0] r_err_cnt;

    assign w_bad = w_capture && !w_dec.legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_bad;
            if (w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Directed bench for sev_seg_decoder: vector table plus hand-written multi-cycle sequences.
// Build with SEV_SEG_DEC_ERR_EN defined to also exercise err/err_cnt.
`timescale 1ns/1ps
module tb_sev_seg_decoder;
    import sev_seg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cat_i;
    logic       an_i;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic       dig0_vld;
    logic       dig1_vld;
    logic       upd;
    logic       stale;
`ifdef SEV_SEG_DEC_ERR_EN
    logic       err;
    logic [7:0] err_cnt;
    int         err_seen = 0;
    int         exp_errcnt = 0;
    int         e0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         upd_seen = 0;
    int         u0;
    logic [3:0] exp_d0;
    logic [3:0] exp_d1;

    typedef struct packed {
        logic       an;
        logic [6:0] cat;
        logic       legal;
        logic [3:0] nib;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    sev_seg_decoder #(
        .GLOBAL_CLOCK_RATE (1000),
        .REFRESH_RATE      (100),
        .SETTLE_CYCLES     (4),
        .SYNC_STAGES       (2),
        .STALE_MULT        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cat_i    (cat_i),
        .an_i     (an_i),
        .dig0     (dig0),
        .dig1     (dig1),
        .dig0_vld (dig0_vld),
        .dig1_vld (dig1_vld),
        .upd      (upd),
        .stale    (stale)
`ifdef SEV_SEG_DEC_ERR_EN
        ,
        .err      (err),
        .err_cnt  (err_cnt)
`endif
    );

    always @(negedge clk) if (upd) upd_seen++;
`ifdef SEV_SEG_DEC_ERR_EN
    always @(negedge clk) if (err) err_seen++;
`endif

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Display-driver model: an switches first, cathodes follow one cycle later.
    task automatic drive_digit(input logic an, input logic [6:0] cat);
        an_i = an;
        tick(1);
        cat_i = cat;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 7'b1111000, 1'b1, 4'h7};
        vecs[1]  = '{1'b1, 7'b1111111, 1'b0, 4'h0};
        vecs[2]  = '{1'b0, 7'b1010101, 1'b0, 4'h0};
        vecs[3]  = '{1'b1, 7'b1000000, 1'b1, 4'h0};
        vecs[4]  = '{1'b0, 7'b0001110, 1'b1, 4'hF};
        vecs[5]  = '{1'b1, 7'b0000011, 1'b1, 4'hB};
        vecs[6]  = '{1'b0, 7'b0000000, 1'b1, 4'h8};
        vecs[7]  = '{1'b1, 7'b0010000, 1'b1, 4'h9};
        vecs[8]  = '{1'b0, 7'b0000110, 1'b1, 4'hE};
        vecs[9]  = '{1'b1, 7'b0100001, 1'b1, 4'hD};
        vecs[10] = '{1'b0, 7'b1000110, 1'b1, 4'hC};
        vecs[11] = '{1'b1, 7'b0100100, 1'b1, 4'h2};
        vecs[12] = '{1'b0, 7'b1111001, 1'b1, 4'h1};
        vecs[13] = '{1'b1, 7'b0011001, 1'b1, 4'h4};
        vecs[14] = '{1'b0, 7'b0000010, 1'b1, 4'h6};
        vecs[15] = '{1'b1, 7'b0000010, 1'b1, 4'h6};
        vecs[16] = '{1'b0, 7'b0000010, 1'b1, 4'h6};

        // Reset with an_i idle and blank cathodes.
        rst_n = 1'b0;
        an_i  = 1'b0;
        cat_i = 7'b1111111;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("reset outputs", {dig1, dig0, dig1_vld, dig0_vld, upd, stale}, 12'h000);
        check("reset upd count", upd_seen, 0);
        check("reset fsm", 32'(dut.r_state), 32'(S_SYNC));
`ifdef SEV_SEG_DEC_ERR_EN
        check("reset err_cnt", err_cnt, 0);
`endif

        // 0x3A via driver model, with exact write latency on the first digit.
        u0 = upd_seen;
        drive_digit(1'b1, 7'b0001000);
        tick(6);
        check("3A early", {dig0_vld, 32'(upd_seen - u0)}, 0);
        tick(1);
        check("3A dig0 write", {dig0_vld, dig0, upd}, {1'b1, 4'hA, 1'b1});
        drive_digit(1'b0, 7'b0110000);
        tick(12);
        check("3A digits", {dig1_vld, dig1, dig0_vld, dig0}, {1'b1, 4'h3, 1'b1, 4'hA});
        check("3A upd pulses", upd_seen - u0, 2);

        // Cathodes glitch every 2 cycles for 10 cycles, then settle on 5.
        u0 = upd_seen;
        drive_digit(1'b1, 7'b0000010);
        for (int i = 0; i < 5; i++) begin
            tick(2);
            cat_i = (i % 2 == 0) ? 7'b0010010 : 7'b0000010;
        end
        check("glitch no upd", upd_seen - u0, 0);
        check("glitch dig0 held", dig0, 4'hA);
        tick(6);
        check("glitch pre-capture", upd_seen - u0, 0);
        tick(1);
        check("glitch capture", {dig0, upd}, {4'h5, 1'b1});
        exp_d0 = 4'h5;
        exp_d1 = 4'h3;

        for (int i = 0; i < NVEC; i++) begin
            u0 = upd_seen;
`ifdef SEV_SEG_DEC_ERR_EN
            e0 = err_seen;
`endif
            drive_digit(vecs[i].an, vecs[i].cat);
            tick(12);
            if (vecs[i].legal) begin
                if (vecs[i].an) exp_d0 = vecs[i].nib;
                else            exp_d1 = vecs[i].nib;
            end
            check($sformatf("vec%0d digits", i), {dig1, dig0}, {exp_d1, exp_d0});
            check($sformatf("vec%0d upd", i), upd_seen - u0, vecs[i].legal ? 1 : 0);
`ifdef SEV_SEG_DEC_ERR_EN
            if (!vecs[i].legal) exp_errcnt++;
            check($sformatf("vec%0d err", i), err_seen - e0, vecs[i].legal ? 0 : 1);
            check($sformatf("vec%0d err_cnt", i), err_cnt, exp_errcnt);
`endif
        end

        // an_i frozen: stale after 4*DIV_BY cycles, digits kept, then recovery.
        drive_digit(1'b1, 7'b0110000);
        tick(36);
        check("stale not yet", {stale, dig0_vld}, 2'b01);
        tick(8);
        check("stale set", {stale, dig1_vld, dig0_vld}, 3'b100);
        check("stale digits held", {dig1, dig0}, {4'h6, 4'h3});
        drive_digit(1'b0, 7'b0001000);
        tick(3);
        check("stale cleared", stale, 1'b0);
        tick(9);
        check("stale recapture", {dig1_vld, dig1, dig0_vld, dig0}, {1'b1, 4'hA, 1'b0, 4'h3});

        // Reset pulse mid-settle on the dig1 slot.
        drive_digit(1'b1, 7'b1111000);
        tick(12);
        check("pre-reset dig0", {dig0_vld, dig0}, {1'b1, 4'h7});
        drive_digit(1'b0, 7'b0100100);
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {dig1, dig0, dig1_vld, dig0_vld, upd, stale}, 12'h000);
`ifdef SEV_SEG_DEC_ERR_EN
        check("async reset err_cnt", err_cnt, 0);
`endif
        tick(1);
        rst_n = 1'b1;
        u0 = upd_seen;
        tick(12);
        check("no partial capture", {dig1, dig0, dig1_vld, dig0_vld, stale}, 11'h000);
        check("no upd after reset", upd_seen - u0, 0);
        drive_digit(1'b1, 7'b0010000);
        tick(12);
        check("reset recovery", {dig1_vld, dig1, dig0_vld, dig0}, {1'b0, 4'h0, 1'b1, 4'h9});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
